// File: rtl/lu_result_buffer.sv
// In-order result buffer between the integer logic unit and the register-file
// write port. Stalls the logic unit via busy when all entries are occupied.
module lu_result_buffer #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lu_valid,
  input  logic [DATA_WIDTH-1:0]     lu_data,
  input  logic [REG_ADDR_WIDTH-1:0] lu_dest,
  output logic                      busy,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_dest,
  output logic                      wb_zero,
  input  logic                      wb_ready,
  output logic [CNT_WIDTH-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]     data_mem_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] dest_mem_q [DEPTH];
  logic                      zero_mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic enq;
  logic deq;

  // Handshakes: a write-back transfer happens on a rising edge where
  // wb_valid && wb_ready; upstream results are taken when lu_valid && !busy
  // and the destination is not the hardwired zero register.
  assign busy     = (count_q == CNT_WIDTH'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign enq      = lu_valid && !busy && (lu_dest != '0);
  assign deq      = wb_valid && wb_ready;
  assign count    = count_q;

  // Outputs are masked while empty so stale storage never leaks out.
  assign wb_data = wb_valid ? data_mem_q[rd_ptr_q] : '0;
  assign wb_dest = wb_valid ? dest_mem_q[rd_ptr_q] : '0;
  assign wb_zero = wb_valid ? zero_mem_q[rd_ptr_q] : 1'b0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through the masked outputs.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem_q[wr_ptr_q] <= lu_data;
      dest_mem_q[wr_ptr_q] <= lu_dest;
      zero_mem_q[wr_ptr_q] <= (lu_data == '0);
    end
  end

endmodule
